// File: rtl/bdiv_48by24.sv
// bdiv_48by24 -- sequential restoring divider, 2*DW-bit dividend by DW-bit divisor.
//
// One quotient bit is produced per clock, so a normal division takes DW+1
// edges from the accepting edge to the done cycle. A zero divisor or a
// quotient that cannot fit in DW bits is resolved on the accepting edge itself.
//
// Handshake: a request is accepted on any rising edge where start=1 and the
// block is not busy (IDLE or DONE). The operands are sampled on that edge.
// A start while busy is dropped. The result is valid in the single cycle
// where done=1. quotient, remainder, dbz and ovf then hold until the next
// accepted request completes (dbz/ovf are cleared on acceptance).
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      request pulse
//   dividend   unsigned dividend, 2*DW bits
//   divisor    unsigned divisor, DW bits
//   busy       high while iterating (RUN)
//   done       one-cycle result-valid pulse (DONE)
//   quotient   result quotient (all-ones on dbz/ovf)
//   remainder  result remainder (zero on dbz/ovf)
//   dbz        divide-by-zero flag
//   ovf        quotient-overflow flag
//   state_dbg  current FSM state (0=IDLE, 1=RUN, 2=DONE) for checkers
module bdiv_48by24 #(
    parameter int DW = 24
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2*DW-1:0] dividend,
    input  logic [DW-1:0]   divisor,
    output logic            busy,
    output logic            done,
    output logic [DW-1:0]   quotient,
    output logic [DW-1:0]   remainder,
    output logic            dbz,
    output logic            ovf,
    output logic [1:0]      state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int CW = $clog2(DW + 1);
    localparam logic [CW-1:0] LAST = CW'(DW - 1);

    state_t        state;
    state_t        state_nxt;

    logic [CW-1:0] cnt;       // iterations completed so far
    logic [DW:0]   prem;      // partial remainder, one spare bit for the shift
    logic [DW-1:0] dvd_lo;    // remaining dividend bits, consumed MSB-first
    logic [DW-1:0] dvs;       // registered divisor
    logic [DW-1:0] quo;       // quotient bits collected so far

    logic          accept;
    logic          dvs_zero;
    logic          too_big;
    logic          last;
    logic [DW:0]   prem_shift;
    logic          q_bit;
    logic [DW:0]   prem_nxt;
    logic [DW-1:0] quo_nxt;

    assign accept   = start && (state != S_RUN);
    assign dvs_zero = (divisor == '0);
    // Upper half >= divisor means the quotient needs more than DW bits.
    assign too_big  = (dividend[2*DW-1:DW] >= divisor);
    assign last     = (cnt == LAST);

    // One restoring step. prem < dvs always holds entering a step, so the
    // shifted value is below 2*dvs and fits in DW+1 bits.
    assign prem_shift = {prem[DW-1:0], dvd_lo[DW-1]};
    assign q_bit      = (prem_shift >= {1'b0, dvs});
    assign prem_nxt   = q_bit ? (prem_shift - {1'b0, dvs}) : prem_shift;
    assign quo_nxt    = {quo[DW-2:0], q_bit};

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_nxt = (dvs_zero || too_big) ? S_DONE : S_RUN;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_RUN: begin
                if (last) begin
                    state_nxt = S_DONE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        busy      = (state == S_RUN);
        done      = (state == S_DONE);
        state_dbg = state;
    end

    // Datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            prem      <= '0;
            dvd_lo    <= '0;
            dvs       <= '0;
            quo       <= '0;
            quotient  <= '0;
            remainder <= '0;
            dbz       <= 1'b0;
            ovf       <= 1'b0;
        end else if (accept) begin
            cnt    <= '0;
            prem   <= {1'b0, dividend[2*DW-1:DW]};
            dvd_lo <= dividend[DW-1:0];
            dvs    <= divisor;
            quo    <= '0;
            dbz    <= 1'b0;
            ovf    <= 1'b0;
            if (dvs_zero) begin
                dbz       <= 1'b1;
                quotient  <= '1;
                remainder <= '0;
            end else if (too_big) begin
                ovf       <= 1'b1;
                quotient  <= '1;
                remainder <= '0;
            end
        end else if (state == S_RUN) begin
            cnt    <= cnt + CW'(1);
            prem   <= prem_nxt;
            dvd_lo <= {dvd_lo[DW-2:0], 1'b0};
            quo    <= quo_nxt;
            // Results are published only as DONE is entered.
            if (last) begin
                quotient  <= quo_nxt;
                remainder <= prem_nxt[DW-1:0];
            end
        end
    end

endmodule
